keypad_scanner: RTL and testbench

- Upstream stage of the barcode entry path: scans a 4x4 active-low matrix keypad, debounces presses and releases, and produces one decoded key code per physical press.
- Digit_out/Digit_valid drive the barcode shift-register controller's Digit_in/ENABLE directly.
- Func_valid reports non-digit keys (A-D, *, #) to the sale-terminal control logic.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_sync2.sv | 25 ++
 rtl/keypad_scanner.sv | 154 +++++++++++++++
 tb/tb_keypad_scanner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 matrix keypad scanner.
// Holds the scanner state encoding, the row/column to key-code map and
// small decode helpers used by keypad_scanner and keypad_sync2.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEB_PRESS,
      PRESSED,
      DEB_RELEASE
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // Idle level of the pulled-up, active-low row lines.
   localparam logic [3:0] ROW_IDLE = 4'hF;

   // KEY_MAP[row][col]; each row is written column 3 down to column 0.
   localparam logic [3:0][3:0][3:0] KEY_MAP = {
      {4'hD, KEY_HASH, 4'h0, KEY_STAR},
      {4'hC, 4'h9,     4'h8, 4'h7},
      {4'hB, 4'h6,     4'h5, 4'h4},
      {4'hA, 4'h3,     4'h2, 4'h1}
   };

   // Index of the lowest-numbered row that reads low (lowest row wins).
   function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Codes 0-9 are digits; A-F are function keys.
   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/keypad_sync2.sv
// keypad_sync2: two-flop synchronizer for the asynchronous keypad row lines.
// Resets to the idle (all rows released) level so no phantom press is seen.
module keypad_sync2
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] sync_p0;

   // Two back-to-back flops: first may go metastable, second feeds the logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= ROW_IDLE;
         q       <= ROW_IDLE;
      end else begin
         sync_p0 <= d;
         q       <= sync_p0;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad one column at a time,
// debounces press and release, and emits one decoded code per press.
// Optional auto-repeat of held digit keys is enabled by defining the macro
// KEYPAD_REPEAT_EN; without it no repeat counter exists.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 5000,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] ROW_in,
   output logic [3:0] COL_out,
   output logic [3:0] Digit_out,
   output logic       Digit_valid,
   output logic       Func_valid,
   output logic       KeyHeld
);

   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("SCAN_DIV must be at least 4");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("REPEAT_CYCLES must be at least 2");
   end

   logic [3:0]       rs;
   state_t           state;
   logic [1:0]       col;
   logic [1:0]       row;
   logic [CNT_W-1:0] cnt;
   logic             row_hi;
   logic [3:0]       key_code;

`ifdef KEYPAD_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
   logic [RPT_W-1:0] rep_cnt;
`endif

   keypad_sync2 u_sync (
      .clk (CLK),
      .rst (RESET),
      .d   (ROW_in),
      .q   (rs)
   );

   // Level of the latched row and the code of the latched key position.
   assign row_hi   = rs[row];
   assign key_code = KEY_MAP[row][col];

   // Scan / debounce state machine with registered outputs; the column
   // stays frozen from detection until the press is abandoned or released.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= SCAN;
         col         <= 2'd0;
         row         <= 2'd0;
         cnt         <= '0;
         COL_out     <= 4'b1110;
         Digit_out   <= 4'h0;
         Digit_valid <= 1'b0;
         Func_valid  <= 1'b0;
         KeyHeld     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt     <= '0;
`endif
      end else begin
         Digit_valid <= 1'b0;
         Func_valid  <= 1'b0;
         case (state)
            SCAN: begin
               if (cnt == SCAN_LAST) begin
                  cnt <= '0;
                  if (rs == ROW_IDLE) begin
                     col     <= col + 2'd1;
                     COL_out <= {COL_out[2:0], COL_out[3]};
                  end else begin
                     row   <= lowest_low_row(rs);
                     state <= DEB_PRESS;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DEB_PRESS: begin
               if (row_hi) begin
                  cnt     <= '0;
                  col     <= col + 2'd1;
                  COL_out <= {COL_out[2:0], COL_out[3]};
                  state   <= SCAN;
               end else if (cnt == DEB_LAST) begin
                  cnt       <= '0;
                  Digit_out <= key_code;
                  if (is_digit(key_code)) Digit_valid <= 1'b1;
                  else                    Func_valid  <= 1'b1;
                  KeyHeld   <= 1'b1;
                  state     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt   <= '0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (row_hi) begin
                  cnt     <= '0;
                  state   <= DEB_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt <= '0;
               end else if (is_digit(Digit_out)) begin
                  if (rep_cnt == RPT_LAST) begin
                     rep_cnt     <= '0;
                     Digit_valid <= 1'b1;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
`endif
               end
            end
            DEB_RELEASE: begin
               if (!row_hi) begin
                  cnt     <= '0;
                  state   <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt <= '0;
`endif
               end else if (cnt == DEB_LAST) begin
                  cnt     <= '0;
                  KeyHeld <= 1'b0;
                  col     <= col + 2'd1;
                  COL_out <= {COL_out[2:0], COL_out[3]};
                  state   <= SCAN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a physical
// keypad model (a pressed key pulls its row low only while its column is
// driven) and an event-timing reference model of the scan/debounce rules.
module tb_keypad_scanner;

   localparam int SD  = 4;
   localparam int DB  = 8;
   localparam int RP  = 40;
`ifdef KEYPAD_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [3:0] ROW_in;
   logic [3:0] COL_out;
   logic [3:0] Digit_out;
   logic       Digit_valid;
   logic       Func_valid;
   logic       KeyHeld;

   keypad_scanner #(
      .SCAN_DIV        (SD),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_CYCLES   (RP)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .ROW_in      (ROW_in),
      .COL_out     (COL_out),
      .Digit_out   (Digit_out),
      .Digit_valid (Digit_valid),
      .Func_valid  (Func_valid),
      .KeyHeld     (KeyHeld)
   );

   always #5 CLK = ~CLK;

   // Keypad model state
   logic [15:0] pressed  = '0;   // bit r*4+c
   logic        raw_mode = 1'b0;
   logic [3:0]  raw_row  = 4'hF;

   always_comb begin
      ROW_in = 4'hF;
      if (raw_mode) begin
         ROW_in = raw_row;
      end else begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (pressed[r*4+c] && !COL_out[c]) ROW_in[r] = 1'b0;
      end
   end

   // Reference model state: scanning restarted with column m_cb right after edge m_base
   int         cyc;
   int         m_base;
   int         m_cb;
   logic [3:0] m_last_code;
   int         n_vec;
   int         n_fail;

   typedef struct {
      int         row;
      int         col;
      logic [3:0] code;
   } key_vec_t;
   key_vec_t tbl[16];

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic check_outputs(input logic [3:0] ecol, input bit edv, input bit efv,
                                input bit ekh, input logic [3:0] ecode);
      chk("col_out",     COL_out,     ecol);
      chk("digit_valid", Digit_valid, edv);
      chk("func_valid",  Func_valid,  efv);
      chk("key_held",    KeyHeld,     ekh);
      chk("digit_out",   Digit_out,   ecode);
   endtask

   function automatic logic [3:0] col_code(input int c);
      logic [3:0] one;
      one = 4'b0001 << c;
      return ~one;
   endfunction

   function automatic int scan_col(input int n);
      return (m_cb + (n - m_base) / SD) % 4;
   endfunction

   // First dwell-end edge on column k whose synchronized sample sees a press
   // that was applied before edge p (two-flop delay => sample input of edge-2).
   function automatic int det_edge(input int p, input int k);
      int j;
      j = 0;
      while (j < 64 && !(((m_cb + j) % 4 == k) && (m_base + SD*(j+1) - 2 >= p))) j++;
      return m_base + SD*(j+1);
   endfunction

   function automatic bit rep_hit(input int n, input int a, input int rv);
      return REP_EN && (n > a) && (n < rv) && (((n - a) % RP) == 0);
   endfunction

   task automatic model_reset();
      cyc = 0;
      m_base = 0;
      m_cb = 0;
      m_last_code = 4'h0;
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check_outputs(col_code(scan_col(cyc)), 1'b0, 1'b0, 1'b0, m_last_code);
      end
   endtask

   // Assert reset between clock edges, verify it acts immediately, release it.
   task automatic async_reset();
      #2 RESET = 1'b1;
      #1;
      check_outputs(4'b1110, 1'b0, 1'b0, 1'b0, 4'h0);
      pressed  = '0;
      raw_mode = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      model_reset();
   endtask

   // Press the keys in mask (all in column k), hold hold_after cycles past the
   // accept, optionally add extra keys mid-hold, then release everything.
   task automatic run_press(input logic [15:0] mask, input int k, input logic [3:0] code,
                            input int hold_after, input logic [15:0] extra);
      int e, a, rv, f;
      bit dig;
      dig = (code < 4'd10);
      pressed = mask;
      e = det_edge(cyc + 1, k);
      a = e + DB;
      while (cyc < a + hold_after) begin
         tick();
         if (cyc == a + hold_after/2) pressed = pressed | extra;
         check_outputs((cyc < e) ? col_code(scan_col(cyc)) : col_code(k),
                       dig && (cyc == a || rep_hit(cyc, a, 1 << 30)),
                       !dig && (cyc == a), cyc >= a,
                       (cyc >= a) ? code : m_last_code);
      end
      pressed = '0;
      rv = cyc + 1 + 2;
      f  = cyc + 1 + 2 + DB;
      while (cyc < f + 6) begin
         tick();
         check_outputs((cyc < f) ? col_code(k) : col_code((k + 1 + (cyc - f) / SD) % 4),
                       dig && rep_hit(cyc, a, rv), 1'b0, cyc < f, code);
      end
      m_base = f;
      m_cb = (k + 1) % 4;
      m_last_code = code;
   endtask

   // Row 2 low 3 cycles, high 1, low 2, then high: detection then abandon.
   task automatic bounce_test();
      int j, d, k;
      j = 0;
      while (m_base + SD*(j+1) - 2 < cyc + 1) j++;
      d = m_base + SD*(j+1);
      k = (m_cb + j) % 4;
      while (cyc < d - 3) begin
         tick();
         check_outputs(col_code(scan_col(cyc)), 1'b0, 1'b0, 1'b0, m_last_code);
      end
      raw_mode = 1'b1;
      for (int t = 0; t < 14; t++) begin
         raw_row = (t < 3 || t == 4 || t == 5) ? 4'b1011 : 4'b1111;
         tick();
         check_outputs((cyc < d) ? col_code(scan_col(cyc)) :
                       (cyc < d + 3) ? col_code(k) : col_code((k + 1 + (cyc - d - 3) / SD) % 4),
                       1'b0, 1'b0, 1'b0, m_last_code);
      end
      raw_mode = 1'b0;
      raw_row  = 4'hF;
      m_base = d + 3;
      m_cb = (k + 1) % 4;
   endtask

   // Press "5" and hit reset after_det cycles past detection.
   task automatic abort_test(input int after_det);
      int e;
      pressed = 16'b1 << 5;
      e = det_edge(cyc + 1, 1);
      while (cyc < e + after_det) tick();
      chk("abort_key_held", KeyHeld, after_det >= DB);
      async_reset();
      idle_check(12);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, gap, hold;
      n_vec = 0;
      n_fail = 0;
      tbl = '{'{0,0,4'h1}, '{0,1,4'h2}, '{0,2,4'h3}, '{0,3,4'hA},
              '{1,0,4'h4}, '{1,1,4'h5}, '{1,2,4'h6}, '{1,3,4'hB},
              '{2,0,4'h7}, '{2,1,4'h8}, '{2,2,4'h9}, '{2,3,4'hC},
              '{3,0,4'hE}, '{3,1,4'h0}, '{3,2,4'hF}, '{3,3,4'hD}};

      // Power-on reset
      repeat (3) @(negedge CLK);
      check_outputs(4'b1110, 1'b0, 1'b0, 1'b0, 4'h0);
      RESET = 1'b0;
      model_reset();
      idle_check(17);

      // Reset mid-scan, then the column walk from column 0
      idle_check(6);
      async_reset();
      idle_check(17);

      // Digit "8" held about 30 cycles
      run_press(16'b1 << (2*4+1), 1, 4'h8, 22, '0);

      // Bounce: no pulse, scanning moves on
      bounce_test();
      idle_check(8);

      // Function key "#"
      run_press(16'b1 << (3*4+2), 2, 4'hF, 5, '0);

      // Rows 1 and 3 on column 0; key "3" pressed during the hold is ignored
      run_press((16'b1 << (1*4+0)) | (16'b1 << (3*4+0)), 0, 4'h4, 20, 16'b1 << (0*4+2));

      // Long hold of "5": repeats only when the feature is built in
      run_press(16'b1 << (1*4+1), 1, 4'h5, 90, '0);

      // Every key position against the key map
      for (int i = 0; i < 16; i++) begin
         run_press(16'b1 << (tbl[i].row*4 + tbl[i].col), tbl[i].col, tbl[i].code, 4, '0);
         idle_check(2);
      end

      // Reset mid-debounce and mid-hold
      abort_test(3);
      abort_test(DB + 3);

      // Randomized sessions
      for (int i = 0; i < 12; i++) begin
         idx  = $urandom_range(15, 0);
         gap  = $urandom_range(9, 0);
         hold = $urandom_range(60, 1);
         idle_check(gap);
         run_press(16'b1 << (tbl[idx].row*4 + tbl[idx].col), tbl[idx].col, tbl[idx].code, hold, '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
